// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 16x oversampling deframer feeding a small show-ahead FIFO
// with sticky overrun / framing-error flags for the APB register slave.
module uart_rx_fifo #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int FIFO_AW   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err,
  output logic [2:0] fsm_state
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic          rx_s1, rxs;
  logic [CW-1:0] tcnt;
  logic          tick;
  logic [2:0]    state;
  logic [3:0]    sc;
  logic [2:0]    bc;
  logic [7:0]    shreg;
  logic          push;
  logic          frame_set;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic               do_push, do_pop, ovr_set;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;
    end
  end

  // Free-running divider; start-bit detection deliberately does not re-phase it.
  assign tick = (tcnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // A good stop sample raises push for exactly the following cycle.
  assign frame_set = tick && (state == STOP) && (sc == 4'd15) && !rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sc    <= '0;
      bc    <= '0;
      shreg <= '0;
      push  <= 1'b0;
    end else begin
      push <= tick && (state == STOP) && (sc == 4'd15) && rxs;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              sc    <= '0;
            end
          end
          START: begin
            if (sc == 4'd7) begin
              sc    <= '0;
              bc    <= '0;
              state <= rxs ? IDLE : DATA;
            end else begin
              sc <= sc + 1'b1;
            end
          end
          DATA: begin
            if (sc == 4'd15) begin
              sc    <= '0;
              shreg <= {rxs, shreg[7:1]};
              if (bc == 3'd7) state <= STOP;
              else            bc    <= bc + 1'b1;
            end else begin
              sc <= sc + 1'b1;
            end
          end
          STOP: begin
            if (sc == 4'd15) begin
              sc    <= '0;
              state <= rxs ? IDLE : BRK;
            end else begin
              sc <= sc + 1'b1;
            end
          end
          BRK: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A pop on an empty FIFO is ignored; a pop on a full FIFO makes room for a same-cycle push.
  assign do_pop  = rd_en && !rx_empty;
  assign do_push = push && (!rx_full || do_pop);
  assign ovr_set = push && rx_full && !do_pop;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (FIFO_AW + 1)'(1);
      2'b01:   count_nxt = count - (FIFO_AW + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_empty <= 1'b1;
      rx_full  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      rx_empty <= (count_nxt == '0);
      rx_full  <= (count_nxt == (FIFO_AW + 1)'(DEPTH));
    end
  end

  assign rx_data = mem[rd_ptr];

  // Set takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at DIV = 1 (16 clk per bit): directed scenarios plus a
// randomized byte stream checked against a queue model of the FIFO and flags.
module tb_uart_rx_fifo;

  localparam int BIT_CLK = 16;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, overrun, frame_err;
  logic [2:0] fsm_state;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  logic       exp_ferr = 1'b0;

  uart_rx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(6_250_000), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .err_clr(err_clr),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .overrun(overrun), .frame_err(frame_err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rxd = 1'b1;
    drive_bit(1'b1);
  endtask

  // Model of a correctly framed byte arriving at the FIFO.
  task automatic model_rx(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_empty"}, 32'(rx_empty), 32'(exp_q.size() == 0));
    chk({tag, "_full"}, 32'(rx_full), 32'(exp_q.size() == DEPTH));
    chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
  endtask

  task automatic pop(input string tag);
    chk({tag, "_empty"}, 32'(rx_empty), 32'(exp_q.size() == 0));
    if (exp_q.size() > 0) chk({tag, "_data"}, 32'(rx_data), 32'(exp_q.pop_front()));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_errs(input string tag);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
    @(negedge clk);
    chk({tag, "_ovr"}, 32'(overrun), 32'(0));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(0));
  endtask

  initial begin
    int lat;
    int waited;
    logic [7:0] b;
    logic [7:0] v55;

    // reset
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(rx_data), 32'(0));
    chk("rst_state", 32'(fsm_state), 32'(0));
    chk_status("rst");
    reset = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);

    // single byte 0xA5 with stop-bit latency measurement
    b = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rxd = 1'b1;
    lat = 0;
    while (rx_empty && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("s1_latency_window", 32'(lat >= 10 && lat <= 13), 32'(1));
    drive_bit(1'b1);
    drive_bit(1'b1);
    model_rx(8'hA5);
    chk_status("s1");
    pop("s1_pop");
    chk("s1_empty_after", 32'(rx_empty), 32'(1));
    pop("s1_pop_on_empty");
    chk_status("s1_after_ignored_pop");

    // fill and overrun
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
      model_rx(8'(i));
      chk_status($sformatf("s2_fill%0d", i));
    end
    for (int i = 0; i < 4; i++) pop($sformatf("s2_pop%0d", i));
    chk_status("s2_drained");
    clear_errs("s2_clr");

    // framing error followed by a long break
    b = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rxd = 1'b0;
    repeat (21 * BIT_CLK) @(negedge clk);
    exp_ferr = 1'b1;
    chk_status("s3_brk");
    clear_errs("s3_clr_in_brk");
    repeat (20 * BIT_CLK) @(negedge clk);
    chk("s3_single_ferr", 32'(frame_err), 32'(0));
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_byte(8'h7E, 1'b1);
    model_rx(8'h7E);
    chk_status("s3_good");
    pop("s3_pop");

    // glitch rejection
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk("s4_state_idle", 32'(fsm_state), 32'(0));
    chk_status("s4");

    // simultaneous push and pop while full
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1);
      model_rx(8'h10 + 8'(i));
    end
    chk_status("s5_full");
    fork
      send_byte(8'h14, 1'b1);
      begin
        waited = 0;
        while (!dut.push && waited < 400) begin
          @(negedge clk);
          waited++;
        end
        chk("s5_push_seen", 32'(dut.push), 32'(1));
        chk("s5_head", 32'(rx_data), 32'(exp_q.pop_front()));
        exp_q.push_back(8'h14);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    chk_status("s5_after");
    for (int i = 0; i < 4; i++) pop($sformatf("s5_pop%0d", i));
    chk_status("s5_drained");

    // randomized byte stream with random pops
    for (int it = 0; it < 12; it++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, 1'b1);
      model_rx(b);
      chk_status($sformatf("rnd%0d", it));
      repeat ($urandom_range(0, 2)) pop($sformatf("rnd%0d_pop", it));
    end
    while (exp_q.size() > 0) pop("rnd_drain");
    clear_errs("rnd_clr");

    // reset in the middle of a character
    send_byte(8'h99, 1'b1);
    model_rx(8'h99);
    v55 = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(v55[i]);
    rxd = v55[3];
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
    chk("s6_data", 32'(rx_data), 32'(0));
    chk("s6_state", 32'(fsm_state), 32'(0));
    chk_status("s6_rst");
    repeat (2 * BIT_CLK) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    chk_status("s6_idle");
    send_byte(8'hC3, 1'b1);
    model_rx(8'hC3);
    chk_status("s6_rx");
    pop("s6_pop");
    chk_status("s6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end of the APB UART peripheral. It sits directly downstream of the MCU's external `rxd` pin.
- Oversamples `rxd` at 16x baud, deframes 8N1 characters, and buffers the bytes in a small show-ahead FIFO.
- The APB UART register slave pops bytes from the FIFO and reads the status and sticky error flags.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line baud rate. Oversample divisor DIV = CLK_FREQ/(BAUD_RATE*16), integer-truncated, must be >= 1.
- FIFO_AW, 2: FIFO address width. Depth = 2**FIFO_AW (default 4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous reset, active-low (asserted at 0).
- rxd  input  1  asynchronous serial line, idle high.
- rd_en  input  1  pop strobe, one byte per cycle while high.
- err_clr  input  1  clears overrun and frame_err.
- rx_data  output  8  FIFO head byte. Valid while rx_empty = 0.
- rx_empty  output  1  FIFO holds no bytes.
- rx_full  output  1  FIFO holds 2**FIFO_AW bytes.
- overrun  output  1  sticky: a received byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset (reset = 0, asynchronous):
  - rx_data = 0, rx_empty = 1, rx_full = 0, overrun = 0, frame_err = 0.
  - Synchronizer flops = 1, FSM = IDLE, all counters and pointers = 0.
  - Reset mid-character abandons the character; nothing is pushed.
- Input path: rxd passes through a 2-flop synchronizer. The FSM uses only the synced value `rxs`.
- Tick generator:
  - Counter runs 0..DIV-1 continuously.
  - `tick` is a 1-cycle pulse when count = DIV-1.
  - No phase reset on start-bit detection.
- FSM. All actions happen on a tick only. Per-bit tick counter `sc` is 4 bits, bit counter `bc` is 3 bits.
  - IDLE: rxs = 0 → START, sc = 0.
  - START: at sc = 7, rxs = 0 → DATA with sc = 0, bc = 0. At sc = 7, rxs = 1 → IDLE (glitch, nothing recorded).
  - DATA: at sc = 15, shift rxs into the shift register LSB-first and sc → 0. After the 8th bit (bc = 7) → STOP.
  - STOP: at sc = 15, sample rxs.
    - rxs = 1 → push the shift register into the FIFO, → IDLE.
    - rxs = 0 → set frame_err, discard the byte, → BRK.
  - BRK: wait for rxs = 1 (checked on tick) → IDLE. A held-low line produces exactly one frame_err event.
- FIFO push/pop:
  - Push is a 1-cycle `push` strobe, asserted in the clk cycle after the STOP sample tick.
  - Pop: rd_en while rx_empty = 1 is ignored (no pointer change).
  - Push while full and rd_en = 0: byte dropped, overrun set, FIFO unchanged.
  - Push and rd_en in the same cycle while full: both succeed, count unchanged, no overrun.
  - Push and rd_en in the same cycle while empty: the pop is ignored and the push succeeds.
- FIFO structure and flags:
  - Show-ahead: rx_data = mem[rd_ptr] combinationally.
  - First byte is visible with rx_empty = 0 one cycle after `push`.
  - Pointers are FIFO_AW bits wide and wrap modulo depth. Occupancy count is FIFO_AW+1 bits.
  - rx_empty = (count == 0); rx_full = (count == depth). Both are registered with the count.
- Sticky flags:
  - err_clr clears overrun and frame_err on the next edge.
  - If a set event and err_clr occur in the same cycle, set wins.
- Latency: last stop-bit sample → rx_empty falls in 2 clk cycles (push + register).

Test Plan:
- Setup: CLK_FREQ = 100_000_000, BAUD_RATE = 6_250_000 (DIV = 1, bit = 16 clk).
- Scenario 1, single byte: send 8N1 0xA5 → rx_empty falls ≤ 2 cycles after the stop-bit midpoint, rx_data = 0xA5. Pulse rd_en → rx_empty = 1.
- Scenario 2, fill and overrun: send 0x01..0x05 with no pops → rx_full = 1 after 0x04, overrun = 1 after 0x05. Pop 4 times → reads 0x01, 0x02, 0x03, 0x04, then rx_empty = 1.
- Scenario 3, framing error: send 0x3C with stop bit low, then hold rxd low for 40 bits, then high → frame_err = 1, FIFO stays empty, no second error. Next good byte 0x7E is received correctly. err_clr → frame_err = 0.
- Scenario 4, glitch rejection: drive rxd low for 4 clk, then high → FSM returns to IDLE, no push, no error.
- Scenario 5, simultaneous push/pop at full: FIFO full with 0x10..0x13, assert rd_en in the push cycle of 0x14 → no overrun, rx_full stays 1, subsequent reads give 0x11, 0x12, 0x13, 0x14.
- Scenario 6, reset mid-character: assert reset during data bit 3 of 0x55 → all outputs return to reset values. After release, 0xC3 is received intact.
